// File: rtl/fpcvt_pkg.sv
// Shared constants and record types for the linear-to-float converter.
// Constants reflect the default build (IN_W=12, SIG_W=4, EXP_W=3).
package fpcvt_pkg;

    localparam int IN_W_DEF  = 12;
    localparam int SIG_W_DEF = 4;
    localparam int EXP_W_DEF = 3;

    localparam int M         = IN_W_DEF - 1;
    localparam int EMAX      = (1 << EXP_W_DEF) - 1;
    localparam int SHIFT_MAX = M - SIG_W_DEF;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [SIG_W_DEF-1:0] sig;
        logic                 sat;
    } fpcvt_t;

    typedef struct packed {
        logic         sign;
        logic [M-1:0] mag;
        logic         sat;
    } fpcvt_s1_t;

    typedef struct packed {
        logic                 sign;
        logic [M-1:0]         mag;
        logic                 sat;
        logic [EXP_W_DEF-1:0] exp;
    } fpcvt_s2_t;

endpackage

// File: rtl/fpcvt_if.sv
// Streaming bus of the converter: sample input channel plus result output channel.
interface fpcvt_if
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int SIG_W = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_sig;
    logic             out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
    );
endinterface

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpcvt_lzc #(
    parameter int WIDTH = 11,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] lz
);
    logic found;

    always_comb begin
        lz    = CNT_W'(WIDTH);
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && din[i]) begin
                lz    = CNT_W'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fpcvt_pipe.sv
// 3-stage valid/ready linear-to-float converter (sign/abs, exponent, significand).
// Define FPCVT_ROUND_EN for round-half-up with carry renormalisation; default truncates.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int SIG_W = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic    clk,
    input  logic    rst,
    fpcvt_if.slave  bus
);
    localparam int MAG_W  = IN_W - 1;
    localparam int SH_MAX = MAG_W - SIG_W;
    localparam int LZ_W   = $clog2(MAG_W + 1);
`ifdef FPCVT_ROUND_EN
    localparam int E_MAX  = (1 << EXP_W) - 1;
`endif

    generate
        if (SH_MAX < 0 || SH_MAX > (1 << EXP_W) - 1) begin : g_bad_cfg
            $error("fpcvt_pipe: EXP_W too small for IN_W/SIG_W");
        end
    endgenerate

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
        logic             sat;
    } st1_t;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
        logic             sat;
        logic [EXP_W-1:0] exp;
    } st2_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             sat;
    } st3_t;

    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    st1_t s1_q, s1_d;
    st2_t s2_q, s2_d;
    st3_t s3_q, s3_d;
    logic s1_ready, s2_ready, s3_ready;

    // Each stage loads when empty or when its successor takes the current contents.
    assign s3_ready     = !s3_valid_q || bus.out_ready;
    assign s2_ready     = !s2_valid_q || s3_ready;
    assign s1_ready     = !s1_valid_q || s2_ready;
    assign bus.in_ready = s1_ready;

    always_comb begin
        s1_valid_d = s1_ready ? bus.in_valid : s1_valid_q;
        s1_d       = s1_q;
        if (s1_ready) begin
            s1_d.sign = bus.in_data[IN_W-1];
            s1_d.sat  = 1'b0;
            if (bus.in_data == {1'b1, {MAG_W{1'b0}}}) begin
                s1_d.mag = '1;
                s1_d.sat = 1'b1;
            end else if (bus.in_data[IN_W-1]) begin
                s1_d.mag = ~bus.in_data[MAG_W-1:0] + 1'b1;
            end else begin
                s1_d.mag = bus.in_data[MAG_W-1:0];
            end
        end
    end

    logic [LZ_W-1:0]  lz;
    logic [EXP_W-1:0] exp_c;

    fpcvt_lzc #(.WIDTH(MAG_W), .CNT_W(LZ_W)) u_lzc (
        .din (s1_q.mag),
        .lz  (lz)
    );

    always_comb begin
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s2_d       = s2_q;
        exp_c      = '0;
        if (int'(lz) < SH_MAX) begin
            exp_c = EXP_W'(SH_MAX - int'(lz));
        end
        if (s2_ready) begin
            s2_d = '{sign: s1_q.sign, mag: s1_q.mag, sat: s1_q.sat, exp: exp_c};
        end
    end

    logic [EXP_W-1:0] exp_r;
    logic [SIG_W-1:0] sig_r;
    logic             sat_r;
`ifdef FPCVT_ROUND_EN
    logic             rnd;
`endif

    always_comb begin
        s3_valid_d = s3_ready ? s2_valid_q : s3_valid_q;
        s3_d       = s3_q;
        exp_r      = s2_q.exp;
        sig_r      = SIG_W'(s2_q.mag >> s2_q.exp);
        sat_r      = s2_q.sat;
`ifdef FPCVT_ROUND_EN
        rnd = (s2_q.exp != '0) && s2_q.mag[s2_q.exp - 1'b1];
        // A carry out of an all-ones significand renormalises into the exponent,
        // or clamps when the exponent is already at its ceiling.
        if (rnd) begin
            if (sig_r != '1) begin
                sig_r = sig_r + 1'b1;
            end else if (exp_r != EXP_W'(E_MAX)) begin
                sig_r = {1'b1, {(SIG_W-1){1'b0}}};
                exp_r = exp_r + 1'b1;
            end else begin
                sat_r = 1'b1;
            end
        end
`endif
        if (s3_ready) begin
            s3_d = '{sign: s2_q.sign, exp: exp_r, sig: sig_r, sat: sat_r};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
        end
    end

    assign bus.out_valid = s3_valid_q;
    assign bus.out_sign  = s3_q.sign;
    assign bus.out_exp   = s3_q.exp;
    assign bus.out_sig   = s3_q.sig;
    assign bus.out_sat   = s3_q.sat;

endmodule
